alarm_video_sequencer: RTL and testbench

ALARM_VIDEO_SEQUENCER -- requirements
Module: alarm_video_sequencer

---
 rtl/alarm_pkg.sv | 15 +
 rtl/sec_tick_gen.sv | 16 +
 rtl/alarm_video_sequencer.sv | 82 ++++++++
 tb/tb_alarm_video_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// alarm_pkg: state encoding and default constants for the alarm video sequencer
package alarm_pkg;
  typedef enum logic [2:0] {
    S_DISARMED  = 3'd0,
    S_EXIT_DLY  = 3'd1,
    S_ARMED     = 3'd2,
    S_ENTRY_DLY = 3'd3,
    S_ALARM     = 3'd4
  } state_t;
  localparam int         DEF_CLK_FREQ    = 50_000_000;
  localparam logic [9:0] DEF_ARM_CODE    = 10'h112;
  localparam int         DEF_EXIT_DELAY  = 15;
  localparam int         DEF_ENTRY_DELAY = 10;
  localparam int         DEF_VID_TIMEOUT = 3;
endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: one-cycle tick every CLK_FREQ cycles, restartable by iCLR
module sec_tick_gen
  import alarm_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iCLR,
  output logic oTICK
);
  localparam int W = $clog2(CLK_FREQ + 1);
  logic [W-1:0] cnt;
  assign oTICK = cnt == W'(CLK_FREQ - 1);
  always_ff @(posedge iCLK) cnt <= (iRST || iCLR || oTICK) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/alarm_video_sequencer.sv
// alarm_video_sequencer: passcode-armed intrusion alarm that powers up video capture with a lock watchdog
module alarm_video_sequencer
  import alarm_pkg::*;
#(
  parameter int         CLK_FREQ    = DEF_CLK_FREQ,
  parameter logic [9:0] ARM_CODE    = DEF_ARM_CODE,
  parameter int         EXIT_DELAY  = DEF_EXIT_DELAY,
  parameter int         ENTRY_DELAY = DEF_ENTRY_DELAY,
  parameter int         VID_TIMEOUT = DEF_VID_TIMEOUT
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iSENSE,
  input  logic [9:0] iCODE,
  input  logic       iENTER,
  input  logic       iTD_STABLE,
  output logic       oVIDEO_EN,
  output logic       oARMED,
  output logic       oALARM,
  output logic [2:0] oSTATE,
  output logic [7:0] oSECONDS,
  output logic       oVIDEO_FAULT
);
  state_t state, ns;
  logic [7:0] timer, nt, wd;
  logic [1:0] bad_cnt, nb;
  logic s1, s2, s3, motion, enter_q, tick, cmd, good, bad, expire;
  assign cmd    = iENTER & ~enter_q;
  assign good   = cmd && iCODE == ARM_CODE;
  assign bad    = cmd && iCODE != ARM_CODE;
  assign expire = tick && timer <= 8'd1;
  sec_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .iCLK (iCLK),
    .iRST (iRST),
    .iCLR (ns != state),
    .oTICK(tick)
  );
  // a good command overrides any expiry or motion seen on the same cycle
  always_comb begin
    if (good) ns = state == S_DISARMED ? S_EXIT_DLY : S_DISARMED;
    else case (state)
      S_EXIT_DLY:  ns = expire ? S_ARMED : state;
      S_ARMED:     ns = motion ? S_ENTRY_DLY : state;
      S_ENTRY_DLY: ns = (expire || (bad && bad_cnt == 2'd2)) ? S_ALARM : state;
      default:     ns = state;
    endcase
    if (ns != state) begin
      nt = ns == S_EXIT_DLY ? 8'(EXIT_DELAY) : ns == S_ENTRY_DLY ? 8'(ENTRY_DELAY) : 8'd0;
      nb = 2'd0;
    end else begin
      nt = (tick && timer != 8'd0) ? timer - 8'd1 : timer;
      nb = (bad && state == S_ENTRY_DLY && bad_cnt != 2'd3) ? bad_cnt + 2'd1 : bad_cnt;
    end
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state                                     <= S_DISARMED;
      timer                                     <= '0;
      bad_cnt                                   <= '0;
      wd                                        <= '0;
      {s1, s2, s3, motion, enter_q}             <= '0;
      {oVIDEO_EN, oARMED, oALARM, oVIDEO_FAULT} <= '0;
      oSTATE                                    <= '0;
      oSECONDS                                  <= '0;
    end else begin
      {s1, s2, s3} <= {iSENSE, s1, s2};
      motion       <= s2 & ~s3;
      enter_q      <= iENTER;
      state        <= ns;
      timer        <= nt;
      bad_cnt      <= nb;
      oSTATE       <= ns;
      oARMED       <= ns inside {S_ARMED, S_ENTRY_DLY, S_ALARM};
      oALARM       <= ns == S_ALARM;
      oVIDEO_EN    <= ns inside {S_ENTRY_DLY, S_ALARM};
      oSECONDS     <= ns inside {S_EXIT_DLY, S_ENTRY_DLY} ? nt : 8'd0;
      wd           <= (!oVIDEO_EN || iTD_STABLE) ? 8'd0 : (tick && wd < 8'(VID_TIMEOUT)) ? wd + 8'd1 : wd;
      oVIDEO_FAULT <= (ns == S_DISARMED && state != S_DISARMED) ? 1'b0 :
                      oVIDEO_FAULT | (oVIDEO_EN & ~iTD_STABLE & tick & (wd >= 8'(VID_TIMEOUT - 1)));
    end
  end
endmodule

// File: tb/tb_alarm_video_sequencer.sv
// tb_alarm_video_sequencer: directed scenarios plus randomized traffic checked against a behavioural model
module tb_alarm_video_sequencer;
  localparam int F = 10, EXD = 2, END = 3, VT = 2;
  localparam logic [9:0] CODE = 10'h112;
  logic clk = 0, rst = 1, sense = 0, enter = 0, td = 1;
  logic [9:0] code = '0;
  logic ven, armed, alarm, fault;
  logic [2:0] st;
  logic [7:0] secs;
  int errors = 0, checks = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;

  alarm_video_sequencer #(.CLK_FREQ(F), .ARM_CODE(CODE), .EXIT_DELAY(EXD), .ENTRY_DELAY(END), .VID_TIMEOUT(VT)) dut (
    .iCLK(clk), .iRST(rst), .iSENSE(sense), .iCODE(code), .iENTER(enter), .iTD_STABLE(td),
    .oVIDEO_EN(ven), .oARMED(armed), .oALARM(alarm), .oSTATE(st), .oSECONDS(secs), .oVIDEO_FAULT(fault)
  );

  // model: state as an integer, seconds left, edges since the last state change
  int m_st, m_sec, m_bc, m_ph, m_wd, mnx;
  bit m_fault, m_ent, mm, mg, mb, mt, men;
  bit [4:1] h;
  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_sec = 0; m_bc = 0; m_ph = 0; m_wd = 0; m_fault = 0; m_ent = 0; h = '0;
    end else begin
      mm = h[3] && !h[4];
      h = {h[3:1], sense};
      mg = enter && !m_ent && code == CODE;
      mb = enter && !m_ent && code != CODE;
      m_ent = enter;
      mt = (m_ph + 1) % F == 0;
      men = m_st >= 3;
      mnx = m_st;
      if (mg) mnx = (m_st == 0) ? 1 : 0;
      else if (m_st == 1 && mt && m_sec == 1) mnx = 2;
      else if (m_st == 2 && mm) mnx = 3;
      else if (m_st == 3 && ((mt && m_sec == 1) || (mb && m_bc == 2))) mnx = 4;
      if (men && !td) begin
        if (mt) m_wd++;
        if (mt && m_wd >= VT) m_fault = 1;
      end else m_wd = 0;
      if (mnx == 0 && m_st != 0) m_fault = 0;
      if (mnx != m_st) begin
        m_ph = 0; m_bc = 0;
        m_sec = (mnx == 1) ? EXD : (mnx == 3) ? END : 0;
      end else begin
        m_ph++;
        if (mt && m_sec > 0) m_sec--;
        if (mb && m_st == 3) m_bc++;
      end
      m_st = mnx;
    end
  end

  logic [14:0] exp_v, act_v;
  always @(negedge clk) if (chk_en) begin
    exp_v = {3'(m_st), m_st >= 2, m_st == 4, m_st >= 3, (m_st == 1 || m_st == 3) ? 8'(m_sec) : 8'd0, m_fault};
    act_v = {st, armed, alarm, ven, secs, fault};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t dut={st,arm,alm,ven,sec,flt}=%h model=%h", $time, act_v, exp_v);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic command(logic [9:0] c);
    code = c; enter = 1; step(1); enter = 0;
  endtask

  initial begin
    step(2);
    chk_en = 1;
    chk("reset_outputs", {st, armed, alarm, ven, secs, fault}, 0);
    rst = 0;
    step(1);
    command(CODE);
    chk("arm_state", st, 1);
    chk("arm_secs", secs, 2);
    step(9);  chk("exit_secs_before_tick", secs, 2);
    step(1);  chk("exit_secs_after_tick", secs, 1);
    step(9);  chk("exit_still", st, 1);
    step(1);  chk("armed_at_20", st, 2);
    sense = 1;
    step(3);  chk("motion_not_yet", st, 2);
    step(1);  chk("entry_state", st, 3); chk("entry_video", ven, 1); chk("entry_secs", secs, 3);
    step(29); chk("alarm_not_yet", alarm, 0);
    step(1);  chk("alarm_at_30", alarm, 1); chk("alarm_state", st, 4);
    td = 0;
    step(19); chk("fault_not_yet", fault, 0);
    step(1);  chk("fault_at_20", fault, 1);
    td = 1;
    step(3);  chk("fault_sticky", fault, 1);
    command(CODE);
    chk("disarm_state", st, 0); chk("disarm_fault", fault, 0); chk("disarm_alarm", alarm, 0);
    sense = 0;
    step(1); command(CODE); step(20); chk("rearm", st, 2);
    sense = 1; step(4); chk("entry2", st, 3);
    step(29); code = CODE; enter = 1; step(1); enter = 0;
    chk("race_state", st, 0); chk("race_alarm", alarm, 0); chk("race_video", ven, 0);
    sense = 0;
    step(1); command(CODE); step(20);
    sense = 1; step(4); chk("entry3", st, 3);
    command(10'h001); step(1); command(10'h001);
    chk("two_bad", alarm, 0);
    step(1); command(10'h001);
    chk("three_bad_alarm", alarm, 1); chk("three_bad_state", st, 4);
    td = 0; step(25); chk("fault_before_rst", fault, 1);
    rst = 1; step(1);
    chk("rst_in_alarm", {st, armed, alarm, ven, secs, fault}, 0);
    rst = 0; td = 1; step(40);
    chk("no_event_after_rst", {st, armed, alarm, ven, secs, fault}, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 15) == 0) sense = ~sense;
      if ($urandom_range(0, 7) == 0) begin
        enter = ~enter;
        code = ($urandom_range(0, 2) == 0) ? CODE : 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 24) == 0) td = ~td;
      step(1);
    end
    rst = 0;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
